poly_note_player: RTL and testbench

POLY_NOTE_PLAYER -- requirements
Module: poly_note_player

---
 rtl/poly_note_pkg.sv | 19 +
 rtl/note_channel.sv | 87 ++++++++
 rtl/poly_note_player.sv | 134 +++++++++++++
 tb/tb_poly_note_player.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_note_pkg.sv
// -----------------------------------------------------------------------------
// poly_note_pkg
// Shared types and default parameter values for the polyphonic note player.
//   ch_state_t   : per-channel state (IDLE / PLAY)
//   DEF_*        : default values for the poly_note_player parameters
// -----------------------------------------------------------------------------
package poly_note_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } ch_state_t;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_CNT_W    = 26;
  localparam int DEF_DUR_W    = 16;
  localparam int DEF_TICK_DIV = 100000;

endpackage

// File: rtl/note_channel.sv
// -----------------------------------------------------------------------------
// note_channel
// One square-wave tone generator with an optional note duration.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   i_load       : load strobe already decoded for this channel
//   i_half       : half-period in clk cycles (0 stops the channel)
//   i_dur        : note length in ticks (0 sustains)
//   i_stop_all   : force IDLE; wins over a simultaneous load
//   i_tick       : duration tick from the shared prescaler
//   o_square     : square wave output, period 2*(half+1) cycles
//   o_active     : 1 while the channel is in PLAY
// -----------------------------------------------------------------------------
module note_channel
  import poly_note_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DUR_W = DEF_DUR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_half,
  input  logic [DUR_W-1:0] i_dur,
  input  logic             i_stop_all,
  input  logic             i_tick,
  output logic             o_square,
  output logic             o_active
);

  ch_state_t        r_state;
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_cnt;
  logic [DUR_W-1:0] r_dur;
  logic             r_sq;

  // Priority: stop_all > load > duration expiry > period counting.
  // Giving load precedence over expiry means a reload on the expiring
  // cycle starts the new note instead of being swallowed by the stop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_half  <= '0;
      r_cnt   <= '0;
      r_dur   <= '0;
      r_sq    <= 1'b0;
    end else if (i_stop_all) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dur   <= '0;
      r_sq    <= 1'b0;
    end else if (i_load) begin
      r_cnt <= '0;
      r_sq  <= 1'b0;
      if (i_half != '0) begin
        r_state <= PLAY;
        r_half  <= i_half;
        r_dur   <= i_dur;
      end else begin
        r_state <= IDLE;
        r_dur   <= '0;
      end
    end else if (r_state == PLAY) begin
      if (i_tick && (r_dur == DUR_W'(1))) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_dur   <= '0;
        r_sq    <= 1'b0;
      end else begin
        // A zero duration never decrements: the note sustains.
        if (i_tick && (r_dur != '0)) begin
          r_dur <= r_dur - DUR_W'(1);
        end
        if (r_cnt == r_half) begin
          r_cnt <= '0;
          r_sq  <= ~r_sq;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_square = r_sq;
  assign o_active = (r_state == PLAY);

endmodule

// File: rtl/poly_note_player.sv
// -----------------------------------------------------------------------------
// poly_note_player
// NUM_CH independent square-wave tone channels with per-note durations,
// a shared duration prescaler, a popcount mixer and a 1-bit audio output.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   load, load_ch         : command strobe and target channel
//   load_half, load_dur   : half-period (0 = stop) and length in ticks (0 = sustain)
//   stop_all              : silence every channel
//   ch_square, ch_active  : per-channel wave and playing flag
//   mix_level             : registered popcount of ch_square
//   audio_out             : registered single-bit audio
// Build option:
//   POLY_NOTE_PLAYER_PWM_EN : audio_out is PWM of mix_level over NUM_CH slots;
//                             otherwise audio_out is the registered OR of ch_square.
// -----------------------------------------------------------------------------
module poly_note_player
  import poly_note_pkg::*;
#(
  parameter  int NUM_CH   = DEF_NUM_CH,
  parameter  int CNT_W    = DEF_CNT_W,
  parameter  int DUR_W    = DEF_DUR_W,
  parameter  int TICK_DIV = DEF_TICK_DIV,
  localparam int LCH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int MIX_W    = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LCH_W-1:0]  load_ch,
  input  logic [CNT_W-1:0]  load_half,
  input  logic [DUR_W-1:0]  load_dur,
  input  logic              stop_all,
  output logic [NUM_CH-1:0] ch_square,
  output logic [NUM_CH-1:0] ch_active,
  output logic [MIX_W-1:0]  mix_level,
  output logic              audio_out
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0]  r_pre;
  logic              w_tick;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_sq;
  logic [NUM_CH-1:0] w_act;
  logic [MIX_W-1:0]  w_pop;
  logic [MIX_W-1:0]  r_mix;
  logic              r_audio;

  // Free-running duration prescaler; tick is high for the last count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (r_pre == PRE_W'(TICK_DIV - 1)) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign w_tick = (r_pre == PRE_W'(TICK_DIV - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // An out-of-range load_ch matches no channel and is dropped.
      assign w_load[gi] = load && (load_ch == LCH_W'(gi));

      note_channel #(
        .CNT_W (CNT_W),
        .DUR_W (DUR_W)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load[gi]),
        .i_half     (load_half),
        .i_dur      (load_dur),
        .i_stop_all (stop_all),
        .i_tick     (w_tick),
        .o_square   (w_sq[gi]),
        .o_active   (w_act[gi])
      );
    end
  endgenerate

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop = w_pop + MIX_W'(w_sq[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mix <= '0;
    end else begin
      r_mix <= w_pop;
    end
  end

`ifdef POLY_NOTE_PLAYER_PWM_EN
  logic [MIX_W-1:0] r_pwm;

  // PWM slot counter cycles 0..NUM_CH-1 so duty is mix_level/NUM_CH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm   <= '0;
      r_audio <= 1'b0;
    end else begin
      if (r_pwm == MIX_W'(NUM_CH - 1)) begin
        r_pwm <= '0;
      end else begin
        r_pwm <= r_pwm + MIX_W'(1);
      end
      r_audio <= (r_pwm < r_mix);
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_audio <= 1'b0;
    end else begin
      r_audio <= |w_sq;
    end
  end
`endif

  assign ch_square = w_sq;
  assign ch_active = w_act;
  assign mix_level = r_mix;
  assign audio_out = r_audio;

endmodule

// File: tb/tb_poly_note_player.sv
// -----------------------------------------------------------------------------
// tb_poly_note_player
// Directed bench for poly_note_player with NUM_CH=3 (so load_ch=3 is out of
// range), TICK_DIV=10. Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_poly_note_player;

  localparam int NUM_CH   = 3;
  localparam int CNT_W    = 8;
  localparam int DUR_W    = 8;
  localparam int TICK_DIV = 10;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        load      = 1'b0;
  logic [1:0]  load_ch   = '0;
  logic [7:0]  load_half = '0;
  logic [7:0]  load_dur  = '0;
  logic        stop_all  = 1'b0;
  logic [2:0]  ch_square;
  logic [2:0]  ch_active;
  logic [1:0]  mix_level;
  logic        audio_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;   // rising edges since reset release (= prescaler phase)

  poly_note_player #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DUR_W    (DUR_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_ch   (load_ch),
    .load_half (load_half),
    .load_dur  (load_dur),
    .stop_all  (stop_all),
    .ch_square (ch_square),
    .ch_active (ch_active),
    .mix_level (mix_level),
    .audio_out (audio_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_load(input logic [1:0] ch, input logic [7:0] h,
                         input logic [7:0] d, input logic stp);
    load      = 1'b1;
    load_ch   = ch;
    load_half = h;
    load_dur  = d;
    stop_all  = stp;
    step();
    load      = 1'b0;
    stop_all  = 1'b0;
    load_half = '0;
    load_dur  = '0;
  endtask

  // Model of the two channels in test_mix, j = edges after ch1 load.
  function automatic logic m_s0(int j);
    return 1'(((j + 1) / 2) % 2);
  endfunction
  function automatic logic m_s1(int j);
    return 1'((j / 4) % 2);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (ch_active !== 3'b000 || ch_square !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ch act=%b sq=%b exp=000/000", ch_active, ch_square);
    end
    n_cmp++;
    if (mix_level !== 2'd0 || audio_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out mix=%0d audio=%b exp=0/0", mix_level, audio_out);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (ch_active !== 3'b000) begin
        n_bad++;
        $display("FAIL idle_after_reset act=%b exp=000", ch_active);
      end
    end
  endtask

  task automatic test_sustain();
    do_load(2'd0, 8'd4, 8'd0, 1'b0);
    n_cmp++;
    if (ch_square[0] !== 1'b0 || ch_active[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL sustain_start sq=%b act=%b exp=0/1", ch_square[0], ch_active[0]);
    end
    for (int k = 1; k <= 40; k++) begin
      logic e;
      step();
      e = 1'((k / 5) % 2);
      n_cmp++;
      if (ch_square[0] !== e || ch_active[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL sustain k=%0d sq=%b act=%b exp=%b/1", k, ch_square[0], ch_active[0], e);
      end
    end
  endtask

  task automatic test_duration();
    while (cyc % TICK_DIV != 0) step();
    do_load(2'd1, 8'd2, 8'd3, 1'b0);
    for (int m = 1; m <= 29; m++) begin
      step();
      if (m == 9 || m == 28) begin
        n_cmp++;
        if (ch_active[1] !== 1'b1 || ch_square[1] !== 1'((m / 3) % 2)) begin
          n_bad++;
          $display("FAIL dur_playing m=%0d act=%b sq=%b exp=1/%0d", m, ch_active[1], ch_square[1], (m / 3) % 2);
        end
      end
      if (m == 29) begin
        n_cmp++;
        if (ch_active[1] !== 1'b0 || ch_square[1] !== 1'b0) begin
          n_bad++;
          $display("FAIL dur_expire act=%b sq=%b exp=0/0", ch_active[1], ch_square[1]);
        end
      end
    end
  endtask

  task automatic test_mix();
    stop_all = 1'b1;
    step();
    stop_all = 1'b0;
    do_load(2'd0, 8'd1, 8'd0, 1'b0);
    do_load(2'd1, 8'd3, 8'd0, 1'b0);
    for (int j = 1; j <= 30; j++) begin
      logic [1:0] pm;
      logic       ea;
      step();
      n_cmp++;
      if (ch_square !== {1'b0, m_s1(j), m_s0(j)}) begin
        n_bad++;
        $display("FAIL mix_sq j=%0d got=%b exp=%b", j, ch_square, {1'b0, m_s1(j), m_s0(j)});
      end
      pm = 2'(m_s0(j - 1)) + 2'(m_s1(j - 1));
      n_cmp++;
      if (mix_level !== pm) begin
        n_bad++;
        $display("FAIL mix_level j=%0d got=%0d exp=%0d", j, mix_level, pm);
      end
`ifdef POLY_NOTE_PLAYER_PWM_EN
      if (j >= 2) begin
        ea = (((cyc - 1) % NUM_CH) < (int'(m_s0(j - 2)) + int'(m_s1(j - 2))));
        n_cmp++;
        if (audio_out !== ea) begin
          n_bad++;
          $display("FAIL mix_pwm j=%0d got=%b exp=%b", j, audio_out, ea);
        end
      end
`else
      ea = m_s0(j - 1) | m_s1(j - 1);
      n_cmp++;
      if (audio_out !== ea) begin
        n_bad++;
        $display("FAIL mix_audio j=%0d got=%b exp=%b", j, audio_out, ea);
      end
`endif
    end
  endtask

  task automatic test_stop_priority();
    do_load(2'd2, 8'd5, 8'd0, 1'b1);
    n_cmp++;
    if (ch_active !== 3'b000 || ch_square !== 3'b000) begin
      n_bad++;
      $display("FAIL stop_prio act=%b sq=%b exp=000/000", ch_active, ch_square);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      n_cmp++;
      if (ch_active !== 3'b000) begin
        n_bad++;
        $display("FAIL stop_hold i=%0d act=%b exp=000", i, ch_active);
      end
      if (i >= 2) begin
        n_cmp++;
        if (mix_level !== 2'd0 || audio_out !== 1'b0) begin
          n_bad++;
          $display("FAIL stop_out i=%0d mix=%0d audio=%b exp=0/0", i, mix_level, audio_out);
        end
      end
    end
  endtask

  task automatic test_retrigger();
    do_load(2'd0, 8'd2, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if (ch_square[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL retrig_pre sq=%b exp=1", ch_square[0]);
    end
    do_load(2'd0, 8'd7, 8'd0, 1'b0);
    n_cmp++;
    if (ch_square[0] !== 1'b0 || ch_active[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL retrig_load sq=%b act=%b exp=0/1", ch_square[0], ch_active[0]);
    end
    for (int n = 1; n <= 20; n++) begin
      logic e;
      if (n == 10) do_load(2'd3, 8'd1, 8'd1, 1'b0);
      else         step();
      e = 1'((n / 8) % 2);
      n_cmp++;
      if (ch_square !== {2'b00, e} || ch_active !== 3'b001) begin
        n_bad++;
        $display("FAIL retrig n=%0d sq=%b act=%b exp=%b/001", n, ch_square, ch_active, {2'b00, e});
      end
    end
  endtask

  task automatic test_reset_mid();
    do_load(2'd2, 8'd3, 8'd5, 1'b0);
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (ch_active !== 3'b101 || ch_square[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset act=%b sq2=%b exp=101/1", ch_active, ch_square[2]);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (ch_active !== 3'b000 || ch_square !== 3'b000 || mix_level !== 2'd0 || audio_out !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset act=%b sq=%b mix=%0d audio=%b exp=000/000/0/0",
               ch_active, ch_square, mix_level, audio_out);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      n_cmp++;
      if (ch_active !== 3'b000 || ch_square !== 3'b000 || mix_level !== 2'd0 || audio_out !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset i=%0d act=%b sq=%b mix=%0d audio=%b exp=000/000/0/0",
                 i, ch_active, ch_square, mix_level, audio_out);
      end
    end
  endtask

  initial begin
    test_reset();
    $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    test_sustain();
    $display("test_sustain done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    test_duration();
    $display("test_duration done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    test_mix();
    $display("test_mix done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    test_stop_priority();
    $display("test_stop_priority done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    test_retrigger();
    $display("test_retrigger done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    test_reset_mid();
    $display("test_reset_mid done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
